// File: rtl/qam16_mapper_pkg.sv
// Shared QAM16 constellation definitions: 3-bit signed levels and the Gray-to-level map,
// used by both the transmit mapper and the receive-side demapper.
package qam16_mapper_pkg;

  localparam int SYM_W = 4;

  localparam logic [2:0] LVL_M3   = 3'b101;
  localparam logic [2:0] LVL_M1   = 3'b111;
  localparam logic [2:0] LVL_P1   = 3'b001;
  localparam logic [2:0] LVL_P3   = 3'b011;
  localparam logic [2:0] LVL_ZERO = 3'b000;

  typedef logic [SYM_W-1:0] symbol_t;

  // Gray-coded pair to level: adjacent levels differ by one bit
  function automatic logic [2:0] gray_to_level(input logic [1:0] g);
    logic [2:0] lvl;
    case (g)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      default: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_mapper_sym_fifo.sv
// Two-entry symbol queue between the bit assembler and the symbol-rate mapper.
// A push into a full queue is accepted only when a pop happens on the same edge.
module sym_fifo
  import qam16_mapper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  symbol_t    wdata,
  input  logic       pop,
  output symbol_t    rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  symbol_t mem [2];
  logic    wr_ptr;
  logic    rd_ptr;
  logic    do_push;
  logic    do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qam16_mapper.sv
// Serial-bit to QAM16 I/Q mapper: assembles 4-bit symbols, queues them, and emits one
// Gray-mapped I/Q pair per SPS-cycle symbol period, held stable for the whole period.
module qam16_mapper
  import qam16_mapper_pkg::*;
#(
  parameter int SPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [2:0] I,
  output logic [2:0] Q,
  output logic       sym_strobe,
  output logic       underflow,
  output logic       underflow_sticky
);

  localparam int PW = $clog2(SPS);

  if ((SPS < 2) || (SPS > 64) || ((SPS & (SPS - 1)) != 0)) begin : g_bad_sps
    $error("qam16_mapper: SPS must be a power of two in 2..64");
  end

  logic [PW-1:0] phase;
  logic [1:0]    bit_cnt;
  logic [2:0]    sr;
  logic          accept;
  logic          sym_done;
  logic          boundary;
  symbol_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;

  assign boundary   = (phase == PW'(SPS - 1));
  assign sym_strobe = (phase == '0);
  assign din_ready  = !((bit_cnt == 2'd3) && fifo_full);
  assign accept     = din_valid && din_ready;
  assign sym_done   = accept && (bit_cnt == 2'd3);

  sym_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sym_done),
    .wdata ({sr, din}),
    .pop   (boundary),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= '0;
    else        phase <= phase + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 2'd0;
      sr      <= 3'd0;
    end else if (accept) begin
      if (bit_cnt == 2'd3) begin
        bit_cnt <= 2'd0;
      end else begin
        sr      <= {sr[1:0], din};
        bit_cnt <= bit_cnt + 2'd1;
      end
    end
  end

  // I/Q only change at the period boundary, so they are stable across phases 0..SPS-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      I                <= LVL_ZERO;
      Q                <= LVL_ZERO;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      underflow        <= boundary && fifo_empty;
      underflow_sticky <= underflow_sticky || (boundary && fifo_empty);
      if (boundary) begin
        if (!fifo_empty) begin
          I <= gray_to_level(head[3:2]);
          Q <= gray_to_level(head[1:0]);
        end else begin
          I <= LVL_ZERO;
          Q <= LVL_ZERO;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_full == (fifo_count == 2'd2)) && (fifo_empty == (fifo_count == 2'd0)));

endmodule

// File: tb/tb_qam16_mapper.sv
// Self-checking bench for qam16_mapper: directed corner sequences and randomized traffic
// against a queue-based reference model (SPS=8), plus a table-driven symbol sweep (SPS=4).
module tb_qam16_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, din8, valid8, ready8, strobe8, uf8, sticky8;
  logic [2:0] i8, q8;
  logic       rst4, din4, valid4, ready4, strobe4, uf4, sticky4;
  logic [2:0] i4, q4;

  qam16_mapper #(.SPS(8)) u_dut8 (
    .clk(clk), .rst_n(rst8), .din(din8), .din_valid(valid8), .din_ready(ready8),
    .I(i8), .Q(q8), .sym_strobe(strobe8), .underflow(uf8), .underflow_sticky(sticky8)
  );

  qam16_mapper #(.SPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4), .din(din4), .din_valid(valid4), .din_ready(ready4),
    .I(i4), .Q(q4), .sym_strobe(strobe4), .underflow(uf4), .underflow_sticky(sticky4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: bits waiting to form a symbol, whole symbols waiting to be sent
  logic       mdl_bits[$];
  logic [3:0] mdl_syms[$];
  int         mdl_phase, mdl_i, mdl_q, cyc;
  bit         mdl_uf, mdl_sticky;

  // Gray pair -> binary index 0..3 -> evenly spaced level 2*b-3
  function automatic int level_of(input logic [1:0] g);
    int b;
    b = (g[1] ? 2 : 0) + ((g[1] ^ g[0]) ? 1 : 0);
    return 2 * b - 3;
  endfunction

  function automatic bit model_ready();
    return !(mdl_bits.size() == 3 && mdl_syms.size() == 2);
  endfunction

  task automatic model_reset();
    mdl_bits.delete();
    mdl_syms.delete();
    mdl_phase  = 0;
    mdl_i      = 0;
    mdl_q      = 0;
    mdl_uf     = 1'b0;
    mdl_sticky = 1'b0;
    cyc        = 0;
  endtask

  task automatic model_edge(input logic v, input logic d);
    bit         acc;
    logic [3:0] s;
    acc    = v && model_ready();
    mdl_uf = 1'b0;
    if (mdl_phase == 7) begin
      if (mdl_syms.size() > 0) begin
        s     = mdl_syms.pop_front();
        mdl_i = level_of(s[3:2]);
        mdl_q = level_of(s[1:0]);
      end else begin
        mdl_i      = 0;
        mdl_q      = 0;
        mdl_uf     = 1'b1;
        mdl_sticky = 1'b1;
      end
    end
    if (acc) begin
      mdl_bits.push_back(d);
      if (mdl_bits.size() == 4) begin
        s = {mdl_bits[0], mdl_bits[1], mdl_bits[2], mdl_bits[3]};
        mdl_syms.push_back(s);
        mdl_bits.delete();
      end
    end
    mdl_phase = (mdl_phase + 1) % 8;
    cyc++;
  endtask

  // One cycle on the SPS=8 instance; entered and left at a falling edge
  task automatic apply_stimulus(input logic v, input logic d);
    valid8 = v;
    din8   = d;
    check_output("ready", ready8, model_ready());
    check_output("I", int'($signed(i8)), mdl_i);
    check_output("Q", int'($signed(q8)), mdl_q);
    check_output("strobe", strobe8, (mdl_phase == 0) ? 1 : 0);
    check_output("underflow", uf8, mdl_uf);
    check_output("sticky", sticky8, mdl_sticky);
    model_edge(v, d);
    @(negedge clk);
  endtask

  task automatic do_reset8();
    rst8   = 1'b0;
    valid8 = 1'b0;
    din8   = 1'b0;
    #1;
    check_output("rst_I", i8, 0);
    check_output("rst_Q", q8, 0);
    check_output("rst_strobe", strobe8, 1);
    check_output("rst_underflow", uf8, 0);
    check_output("rst_sticky", sticky8, 0);
    check_output("rst_ready", ready8, 1);
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] sym;
    logic [2:0] exp_i;
    logic [2:0] exp_q;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0] pat;
    logic [3:0] cur;
    int         win_acc;
    int         k;

    vecs[0]  = '{4'h0, 3'b101, 3'b101};
    vecs[1]  = '{4'h1, 3'b101, 3'b111};
    vecs[2]  = '{4'h2, 3'b101, 3'b011};
    vecs[3]  = '{4'h3, 3'b101, 3'b001};
    vecs[4]  = '{4'h4, 3'b111, 3'b101};
    vecs[5]  = '{4'h5, 3'b111, 3'b111};
    vecs[6]  = '{4'h6, 3'b111, 3'b011};
    vecs[7]  = '{4'h7, 3'b111, 3'b001};
    vecs[8]  = '{4'h8, 3'b011, 3'b101};
    vecs[9]  = '{4'h9, 3'b011, 3'b111};
    vecs[10] = '{4'hA, 3'b011, 3'b011};
    vecs[11] = '{4'hB, 3'b011, 3'b001};
    vecs[12] = '{4'hC, 3'b001, 3'b101};
    vecs[13] = '{4'hD, 3'b001, 3'b111};
    vecs[14] = '{4'hE, 3'b001, 3'b011};
    vecs[15] = '{4'hF, 3'b001, 3'b001};

    rst8 = 1'b0; valid8 = 1'b0; din8 = 1'b0;
    rst4 = 1'b0; valid4 = 1'b0; din4 = 1'b0;
    model_reset();
    @(negedge clk);

    $display("[TB] idle after reset");
    do_reset8();
    for (int c = 0; c < 17; c++) begin
      if (c == 0 || c == 8) check_output("idle_strobe", strobe8, 1);
      if (c == 8 || c == 16) check_output("idle_underflow", uf8, 1);
      if (c == 7) check_output("idle_sticky_pre", sticky8, 0);
      if (c >= 8) check_output("idle_sticky", sticky8, 1);
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] bits 0000 then 1011");
    do_reset8();
    pat = 8'b0000_1011;
    for (int c = 0; c < 24; c++) begin
      if (c >= 8 && c < 16) begin
        check_output("sym0_I", int'($signed(i8)), -3);
        check_output("sym0_Q", int'($signed(q8)), -3);
      end
      if (c >= 16) begin
        check_output("sym1_I", int'($signed(i8)), 3);
        check_output("sym1_Q", int'($signed(q8)), 1);
      end
      apply_stimulus((c < 8) ? 1'b1 : 1'b0, (c < 8) ? pat[7 - c] : 1'b0);
    end

    $display("[TB] continuous valid, backpressure and mid-symbol reset");
    do_reset8();
    win_acc = 0;
    for (int c = 0; c < 48; c++) begin
      if (c == 15) check_output("full_stall_ready", ready8, 0);
      if (c == 16) check_output("full_resume_ready", ready8, 1);
      if (c >= 16 && ready8) win_acc++;
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)));
    end
    check_output("accepts_per_32_cycles", win_acc, 16);
    for (int c = 48; c < 52; c++) begin
      apply_stimulus((c < 51) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end
    do_reset8();
    for (int c = 0; c < 24; c++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] randomized traffic");
    do_reset8();
    for (int c = 0; c < 600; c++) begin
      apply_stimulus(((c % 100) < 80) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] SPS=4 symbol sweep");
    valid8 = 1'b0;
    rst4   = 1'b1;
    for (int c = 0; c < 72; c++) begin
      if (c < 64) begin
        cur    = vecs[c / 4].sym;
        valid4 = 1'b1;
        din4   = cur[3 - (c % 4)];
      end else begin
        valid4 = 1'b0;
        din4   = 1'b0;
      end
      check_output("sweep_strobe", strobe4, ((c % 4) == 0) ? 1 : 0);
      check_output("sweep_ready", ready4, 1);
      if (c == 4) check_output("sweep_first_underflow", uf4, 1);
      if (c >= 4) check_output("sweep_sticky", sticky4, 1);
      if (c >= 8) begin
        k = (c - 8) / 4;
        check_output("sweep_I", int'(i4), int'(vecs[k].exp_i));
        check_output("sweep_Q", int'(q4), int'(vecs[k].exp_q));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
